i2c_scl_gen: RTL

Parametrised SCL timing generator for the I2C master path, clocked from the 27 MHz system clock. It produces SCL as an open-drain drive enable, plus single-cycle phase strobes that the byte/bit sequencer uses for data-change and sample points. The quarter-period is programmable at run time and re-latched once per SCL period. It honours slave clock stretching, and a clean start/stop is gated by `en`.

---
 rtl/i2c_pkg.sv | 15 +
 rtl/i2c_qcnt.sv | 22 ++
 rtl/i2c_scl_gen.sv | 75 +++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, phase codes and divider floor for the I2C master path
package i2c_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW_A,
        ST_LOW_B,
        ST_HIGH_A,
        ST_HIGH_B
    } state_t;
    localparam logic [1:0] PH_LOW_A  = 2'd0;
    localparam logic [1:0] PH_LOW_B  = 2'd1;
    localparam logic [1:0] PH_HIGH_A = 2'd2;
    localparam logic [1:0] PH_HIGH_B = 2'd3;
    localparam int I2C_MIN_DIV = 4;
endpackage

// File: rtl/i2c_qcnt.sv
// i2c_qcnt: quarter-period counter, 0..q-1 with wrap; tc flags the last enabled count
module i2c_qcnt #(
    parameter int W = 16
) (
    input  logic         clk27m,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] q,
    output logic         tc
);
    logic [W-1:0] cnt;
    assign tc = en && (cnt == q - W'(1));
    always_ff @(posedge clk27m or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen: SCL open-drain timing generator with phase strobes and clock-stretch support
// tick_rise and stretch are registered state qualified by the already-synchronised scl_in.
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int MIN_DIV = I2C_MIN_DIV
) (
    input  logic             clk27m,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             scl_in,
    output logic             scl_oe,
    output logic [1:0]       phase,
    output logic             tick_fall,
    output logic             tick_low_mid,
    output logic             tick_rise,
    output logic             tick_high_mid,
    output logic             busy,
    output logic             stretch
);
    state_t           state, state_nx;
    logic [DIV_W-1:0] q;
    logic             tc, cnt_en, rise_done;
    // HIGH_A only advances once the bus really is high
    assign cnt_en    = (state != ST_IDLE) && (state != ST_HIGH_A || scl_in);
    assign tick_rise = (state == ST_HIGH_A) && scl_in && !rise_done;
    assign stretch   = (state == ST_HIGH_A) && !scl_in;
    i2c_qcnt #(.W(DIV_W)) u_qcnt (
        .clk27m(clk27m),
        .rst   (rst),
        .load  (state == ST_IDLE),
        .en    (cnt_en),
        .q     (q),
        .tc    (tc)
    );
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:   state_nx = en ? ST_LOW_A : ST_IDLE;
            ST_LOW_A:  state_nx = tc ? ST_LOW_B : ST_LOW_A;
            ST_LOW_B:  state_nx = tc ? ST_HIGH_A : ST_LOW_B;
            ST_HIGH_A: state_nx = tc ? ST_HIGH_B : ST_HIGH_A;
            ST_HIGH_B: state_nx = tc ? (en ? ST_LOW_A : ST_IDLE) : ST_HIGH_B;
            default:   state_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk27m or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            q             <= DIV_W'(MIN_DIV);
            rise_done     <= 1'b0;
            scl_oe        <= 1'b0;
            phase         <= PH_LOW_A;
            busy          <= 1'b0;
            tick_fall     <= 1'b0;
            tick_low_mid  <= 1'b0;
            tick_high_mid <= 1'b0;
        end else begin
            state         <= state_nx;
            if (state_nx == ST_LOW_A && state != ST_LOW_A)
                q <= (div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div;
            rise_done     <= (state == ST_HIGH_A) && (rise_done || scl_in);
            scl_oe        <= (state_nx == ST_LOW_A) || (state_nx == ST_LOW_B);
            busy          <= state_nx != ST_IDLE;
            phase         <= (state_nx == ST_LOW_B)  ? PH_LOW_B  :
                             (state_nx == ST_HIGH_A) ? PH_HIGH_A :
                             (state_nx == ST_HIGH_B) ? PH_HIGH_B : PH_LOW_A;
            tick_fall     <= (state_nx == ST_LOW_A)  && (state != ST_LOW_A);
            tick_low_mid  <= (state_nx == ST_LOW_B)  && (state != ST_LOW_B);
            tick_high_mid <= (state_nx == ST_HIGH_B) && (state != ST_HIGH_B);
        end
    end
endmodule
